instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the core decode/register-read stage.
//  - Holds the program counter and issues word reads to a synchronous instruction memory (1-cycle read latency).
//  - Buffers returned words with their PC in a small prefetch FIFO.
//  - Hands {pc, instr} to decode over a valid/ready handshake.
//  - Control flow change: a redirect from execute flushes the FIFO and restarts fetch.
// PARAMETERS
//  XLEN        32  datapath / PC width
//  RESET_PC    0   PC loaded on reset; word aligned
//  FIFO_DEPTH  2   prefetch entries; >=2 required for full throughput
//  IMEM_AW     10  instruction memory word-address width
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        asynchronous, active-low reset
//  run             in   1        fetch enable; 0 = issue no new requests
//  redirect_valid  in   1        taken branch/jump: restart fetch at redirect_pc
//  redirect_pc     in   XLEN     new fetch PC; bits [1:0] ignored (forced 0)
//  imem_req        out  1        read strobe to instruction memory
//  imem_addr       out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
//  imem_rdata      in   32       read data, valid the cycle after imem_req
//  if_valid        out  1        FIFO head holds a valid {pc, instr}
//  if_ready        in   1        decode accepts the head this cycle
//  if_pc           out  XLEN     PC of head instruction
//  if_instr        out  32       head instruction word
//  prog_cnt        out  XLEN     current fetch PC (next address to request)
// BEHAVIOUR
//  Reset (rst=0, async)
//   - fetch_pc=RESET_PC; FIFO empty; inflight=0; kill=0.
//   - Outputs: if_valid=0, imem_req=0, prog_cnt=RESET_PC, if_pc/if_instr=0.
//  Definitions
//   - pop = if_valid & if_ready.
//   - credit = (count + inflight - pop) < FIFO_DEPTH.
//  Request path
//   - imem_req = run & ~redirect_valid & credit (combinational).
//   - On each imem_req: fetch_pc += 4 (mod 2^XLEN; 0xFFFFFFFC wraps to 0).
//   - inflight <= imem_req.
//   - The request PC is latched alongside the request for the FIFO write.
//  Response path
//   - inflight=1 and kill=0: {req_pc, imem_rdata} is pushed at the end of that cycle.
//   - Credit guarantees the FIFO is never overrun.
//  Latency and throughput
//   - Request in cycle N -> if_valid in cycle N+2.
//   - With if_ready held high: one instruction per cycle sustained.
//  Handshake
//   - if_pc/if_instr are held stable while if_valid=1 and if_ready=0.
//   - Ordering is strict program order.
//  Redirect (cycle R)
//   - No request in R.
//   - FIFO cleared at end of R; a pop in R is discarded (flush wins).
//   - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - A request in flight during R sets kill, and its response is dropped.
//   - First request at the new PC is in R+1; if_valid is 0 in R+1.
//  run=0
//   - No new requests.
//   - An in-flight response is still buffered.
//   - The FIFO still drains to decode.
//   - fetch_pc holds.
//  run=0 and redirect together: fetch_pc is updated and the FIFO is flushed; fetch stays idle until run=1.
//  Reset mid-operation: all state returns to reset values immediately, and the in-flight response is lost.
// TESTING
//  1. Hold rst=0, then release with run=0 -> if_valid=0, imem_req=0, prog_cnt=0 for 10 cycles.
//  2. Memory word k = 0x1000+k, run=1, if_ready=1 -> from cycle 2: if_pc 0,4,8..., if_instr 0x1000,0x1001,... every cycle.
//  3. Streaming, if_ready=0 for 5 cycles -> head held stable, imem_req drops once FIFO+inflight=2; order resumes with no loss or duplicate.
//  4. Redirect to 0x40 while head pc=0x8 and a request is in flight -> next if_pc=0x40; pcs 0xC/0x10 never appear.
//  5. redirect_pc=0xFFFFFFFC, IMEM_AW=30, run=1 -> if_pc sequence 0xFFFFFFFC, 0x0, 0x4.
//  6. Drop run for 3 cycles mid-stream, then assert rst=0 mid-fetch -> buffered entries drain while run=0; rst clears if_valid immediately, and restart is from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Generic synchronous FIFO, used here as the fetch stage prefetch buffer.
// Latency: a pushed entry is visible at the read port on the following cycle.
// Backpressure: wr_rdy drops when full; flush empties it and overrides push and pop.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic [CW-1:0]    count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign wr_rdy = (count != FULL_CNT);
   assign rd_vld = (count != '0);
   assign rd_dat = mem[rd_ptr];
   assign do_wr  = wr_vld & wr_rdy;
   assign do_rd  = rd_vld & rd_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
         end
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end
endmodule

// Fetch stage: PC, instruction memory requests, prefetch buffer, handoff to decode.
// Latency: request in cycle N gives if_valid in N+2; one instruction per cycle sustained.
// Backpressure: requests issue only with a free FIFO slot reserved (count + inflight - pop).
module instr_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2,
   parameter int              IMEM_AW    = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [XLEN-1:0]    if_pc,
   output logic [31:0]        if_instr,
   output logic [XLEN-1:0]    prog_cnt
);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_ent_t;

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic            inflight;
   logic            kill;
   logic            pop;
   logic            credit;
   logic            push;
   logic            fifo_wr_rdy;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   fetch_ent_t      push_dat;
   fetch_ent_t      head_dat;
   logic            unused_bits;

   assign pop       = if_valid & if_ready;
   // The in-flight word already owns a slot, so it counts against the FIFO.
   assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
   assign credit    = occupancy < DEPTH_L;
   assign imem_req  = rst & run & ~redirect_valid & credit;
   assign imem_addr = fetch_pc[IMEM_AW+1:2];
   assign prog_cnt  = fetch_pc;

   assign push           = inflight & ~kill;
   assign push_dat.pc    = req_pc;
   assign push_dat.instr = imem_rdata;
   assign if_pc          = head_dat.pc;
   assign if_instr       = head_dat.instr;
   assign unused_bits    = ^{redirect_pc[1:0], fifo_wr_rdy};

   fifo #(
      .WIDTH ($bits(fetch_ent_t)),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_prefetch (
      .clk    (clk),
      .rst    (rst),
      .flush  (redirect_valid),
      .wr_vld (push),
      .wr_rdy (fifo_wr_rdy),
      .wr_dat (push_dat),
      .rd_vld (if_valid),
      .rd_rdy (if_ready),
      .rd_dat (head_dat),
      .count  (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         kill     <= 1'b0;
      end else begin
         inflight <= imem_req;
         // Guards the buffer against a word from the old path landing after the flush.
         kill     <= redirect_valid & inflight;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         end else if (imem_req) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (imem_req) begin
            req_pc <= fetch_pc;
         end
      end
   end

   no_overrun: assert property (@(posedge clk) disable iff (!rst) push |-> fifo_wr_rdy);

   head_stable: assert property (@(posedge clk) disable iff (!rst)
      (if_valid && !if_ready && !redirect_valid) |=> (if_valid && $stable(head_dat)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner-case sequences and a
// random run checked against a queue-based model of outstanding fetches.
module tb_instr_fetch_unit;
   localparam int DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk;
   logic        rst;
   logic        run;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] prog_cnt;

   int errors = 0;
   int checks = 0;

   instr_fetch_unit #(
      .XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .IMEM_AW(30)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .prog_cnt       (prog_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return 32'h1000 + {2'b00, a};
   endfunction

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: every issued request is an outstanding entry until decode takes it.
   typedef struct {
      logic [31:0] pc;
      int          avail;
   } ent_t;

   ent_t        q[$];
   logic [31:0] popped[$];
   logic [31:0] m_pc;
   int          cyc;

   task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
      logic exp_valid;
      logic exp_req;
      logic p;
      int   occ;
      @(negedge clk);
      run = r; redirect_valid = rv; redirect_pc = rp; if_ready = rdy;
      #1;
      exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
      p         = exp_valid & rdy;
      occ       = q.size() - (p ? 1 : 0);
      exp_req   = r & ~rv & (occ < DEPTH);
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      chk("prog_cnt", prog_cnt, m_pc);
      chk("if_valid", 32'(if_valid), 32'(exp_valid));
      if (exp_valid && if_valid) begin
         chk("if_pc", if_pc, q[0].pc);
         chk("if_instr", if_instr, mem_word(q[0].pc[31:2]));
      end
      if (exp_req && imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc[31:2]));
      if (rv) begin
         q.delete();
         m_pc = {rp[31:2], 2'b00};
      end else begin
         if (p) begin
            popped.push_back(q[0].pc);
            void'(q.pop_front());
         end
         if (exp_req) begin
            q.push_back('{m_pc, cyc + 2});
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic apply_reset();
      run = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0; redirect_pc = '0;
      rst = 1'b0;
      q.delete();
      m_pc = RST_PC;
      cyc  = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic mid_reset();
      rst = 1'b0;
      #1;
      chk("rst if_valid", 32'(if_valid), 32'd0);
      chk("rst imem_req", 32'(imem_req), 32'd0);
      chk("rst prog_cnt", prog_cnt, RST_PC);
      chk("rst if_pc", if_pc, 32'd0);
      chk("rst if_instr", if_instr, 32'd0);
   endtask

   typedef struct {
      logic        run;
      logic        rdy;
      logic        req;
      logic [31:0] prog;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   vec_t vec[12];

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;
      vec[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,  32'h0};
      vec[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,  32'h0};
      vec[2]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,  32'h0};
      vec[3]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0,  32'h0};
      vec[4]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0,  32'h0};
      vec[5]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0,  32'h1000};
      vec[6]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4,  32'h1001};
      vec[7]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8,  32'h1002};
      vec[8]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'hC,  32'h1003};
      vec[9]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'hC,  32'h1003};
      vec[10] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC,  32'h1003};
      vec[11] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'h1004};

      rst = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      #2;
      mid_reset();
      apply_reset();

      // Idle after reset with run low.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // Directed vector table from a fresh reset.
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         run = vec[i].run; if_ready = vec[i].rdy; redirect_valid = 1'b0;
         #1;
         chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vec[i].req));
         chk($sformatf("vec%0d prog_cnt", i), prog_cnt, vec[i].prog);
         chk($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vec[i].valid));
         if (vec[i].valid) begin
            chk($sformatf("vec%0d if_pc", i), if_pc, vec[i].pc);
            chk($sformatf("vec%0d if_instr", i), if_instr, vec[i].instr);
         end
      end

      // Stall decode for 5 cycles mid-stream, then resume.
      apply_reset();
      popped.delete();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      bad = 0;
      for (int i = 0; i < popped.size(); i++) if (popped[i] != 32'(i * 4)) bad++;
      chk("stall order", 32'(bad), 32'd0);

      // Redirect while head is 0x8 and 0xC is in flight.
      apply_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      popped.delete();
      step(1'b1, 1'b1, 32'h40, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("redir first pc", (popped.size() > 0) ? popped[0] : 32'hDEAD, 32'h40);
      bad = 0;
      foreach (popped[i]) if (popped[i] == 32'hC || popped[i] == 32'h10) bad++;
      chk("redir stale pcs", 32'(bad), 32'd0);

      // PC wrap at the top of the address space.
      popped.delete();
      step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("wrap pc0", (popped.size() > 0) ? popped[0] : 32'hDEAD, 32'hFFFF_FFFC);
      chk("wrap pc1", (popped.size() > 1) ? popped[1] : 32'hDEAD, 32'h0);
      chk("wrap pc2", (popped.size() > 2) ? popped[2] : 32'hDEAD, 32'h4);

      // run dropped for 3 cycles, then reset in the middle of fetch.
      apply_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("drain empty", 32'(if_valid), 32'd0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      mid_reset();
      apply_reset();
      popped.delete();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("restart pc", (popped.size() > 0) ? popped[0] : 32'hDEAD, RST_PC);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic        r;
         logic        rv;
         logic        rd;
         logic [31:0] rp;
         if ($urandom_range(0, 399) == 0) begin
            mid_reset();
            apply_reset();
         end
         r  = ($urandom_range(0, 9) < 8);
         rv = ($urandom_range(0, 19) == 0);
         rd = ($urandom_range(0, 9) < 7);
         rp = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                          : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
         step(r, rv, rp, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
